// File: rtl/de_bus_arbiter_pkg.sv
// Shared definitions for the frame-store bus arbiter: default widths,
// FSM state encoding and read/write encoding.
package de_bus_arbiter_pkg;

  localparam int DEF_ADDR_W = 18;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_NBYTE_W = DEF_DATA_W / 8;

  localparam logic RNW_READ  = 1'b1;
  localparam logic RNW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/de_bus_arbiter_rr_pick.sv
// Round-robin picker: first requester strictly after i_last, wrapping to the
// lowest requester at or below i_last.
module de_bus_arbiter_rr_pick #(
  parameter int N = 2,
  localparam int LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [LW-1:0] i_last,
  output logic [N-1:0]  o_gnt,
  output logic [LW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!o_any && i_req[i] && (i > int'(i_last))) begin
        o_gnt[i] = 1'b1;
        o_idx    = LW'(i);
        o_any    = 1'b1;
      end
    end
    // Nobody above the pointer: the lowest requester overall is the wrap winner.
    for (int i = 0; i < N; i++) begin
      if (!o_any && i_req[i]) begin
        o_gnt[i] = 1'b1;
        o_idx    = LW'(i);
        o_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/de_bus_arbiter.sv
// Frame-store bus arbiter: round-robin among N_CLIENTS masters, one transfer
// at a time, registered memory-side outputs and an optional ack watchdog.
module de_bus_arbiter
  import de_bus_arbiter_pkg::*;
#(
  parameter int N_CLIENTS = 2,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TIMEOUT   = 255,
  localparam int NBYTE_W  = DATA_W / 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_CLIENTS-1:0]         c_req,
  output logic [N_CLIENTS-1:0]         c_ack,
  input  logic [N_CLIENTS*ADDR_W-1:0]  c_addr,
  input  logic [N_CLIENTS*NBYTE_W-1:0] c_nbyte,
  input  logic [N_CLIENTS-1:0]         c_rnw,
  input  logic [N_CLIENTS*DATA_W-1:0]  c_w_data,
  output logic [DATA_W-1:0]            c_r_data,
  output logic                         c_err,
  output logic [N_CLIENTS-1:0]         grant,
  output logic                         busy,
  output logic                         bus_err,
  input  logic                         err_clr,
  output logic                         de_req,
  input  logic                         de_ack,
  output logic [ADDR_W-1:0]            de_addr,
  output logic [NBYTE_W-1:0]           de_nbyte,
  output logic                         de_rnw,
  output logic [DATA_W-1:0]            de_w_data,
  input  logic [DATA_W-1:0]            de_r_data
);

  localparam int LW   = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  state_e              r_state;
  logic [LW-1:0]       r_last;
  logic [WD_W-1:0]     r_wd;

  logic [N_CLIENTS-1:0] w_gnt;
  logic [LW-1:0]        w_idx;
  logic                 w_any;
  logic                 w_to;
  logic [ADDR_W-1:0]    w_addr;
  logic [NBYTE_W-1:0]   w_nbyte;
  logic                 w_rnw;
  logic [DATA_W-1:0]    w_wdata;

  de_bus_arbiter_rr_pick #(.N(N_CLIENTS)) u_pick (
    .i_req  (c_req),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  always_comb begin
    w_addr  = '0;
    w_nbyte = '0;
    w_rnw   = RNW_WRITE;
    w_wdata = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (w_gnt[i]) begin
        w_addr  = c_addr[i*ADDR_W +: ADDR_W];
        w_nbyte = c_nbyte[i*NBYTE_W +: NBYTE_W];
        w_rnw   = c_rnw[i];
        w_wdata = c_w_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // r_wd counts completed XFER cycles, so the abort edge ends cycle TIMEOUT.
  assign w_to = (r_state == ST_XFER) && !de_ack && (TIMEOUT != 0) &&
                (int'(r_wd) == TIMEOUT - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_last    <= LW'(N_CLIENTS - 1);
      r_wd      <= '0;
      c_ack     <= '0;
      c_r_data  <= '0;
      c_err     <= 1'b0;
      grant     <= '0;
      busy      <= 1'b0;
      bus_err   <= 1'b0;
      de_req    <= 1'b0;
      de_addr   <= '0;
      de_nbyte  <= '0;
      de_rnw    <= 1'b0;
      de_w_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            de_addr   <= w_addr;
            de_nbyte  <= w_nbyte;
            de_rnw    <= w_rnw;
            de_w_data <= w_wdata;
            de_req    <= 1'b1;
            grant     <= w_gnt;
            busy      <= 1'b1;
            r_last    <= w_idx;
            r_wd      <= '0;
            r_state   <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (de_ack) begin
            c_r_data <= de_r_data;
            de_req   <= 1'b0;
            c_ack    <= grant;
            r_state  <= ST_DONE;
          end else if (w_to) begin
            c_r_data <= '0;
            c_err    <= 1'b1;
            de_req   <= 1'b0;
            c_ack    <= grant;
            r_state  <= ST_DONE;
          end else begin
            r_wd <= r_wd + WD_W'(1);
          end
        end
        ST_DONE: begin
          c_ack    <= '0;
          c_err    <= 1'b0;
          c_r_data <= '0;
          grant    <= '0;
          busy     <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      // A fresh abort outranks a simultaneous clear.
      if (w_to)
        bus_err <= 1'b1;
      else if (err_clr)
        bus_err <= 1'b0;
    end
  end

endmodule
